// File: rtl/date_set_ctrl.sv
// ---------------------------------------------------------------------------
// date_set_ctrl
//
// Mode/adjust controller for a calendar date (day, month, year). In RUN it
// gates the hour-rollover pulse onto the day counter enable. btn_mode steps
// through SET_DAY -> SET_MONTH -> SET_YEAR -> RUN. In a set state btn_up or
// btn_down produce one-cycle adjust pulses for the selected field, with
// hold-to-repeat. An idle set state falls back to RUN after a timeout. It also
// decodes the month length class and the leap-year flag from the BCD date.
//
// Parameters:
//   HOLD_CYC    cycles a lone button is held before auto-repeat starts
//   RPT_CYC     cycles between auto-repeat pulses
//   TIMEOUT_CYC idle cycles in a set state before returning to RUN
//   CNT_W       width of the internal hold/repeat/timeout counters
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   btn_mode/btn_up/btn_down    debounced, synchronized button levels
//   carry_h                     hour-rollover pulse
//   month_ten/month_unit        BCD month
//   year_ten/year_unit          BCD year 00-99
//   en_d                        day counter run enable (carry_h in RUN only)
//   up_d/down_d/up_m/down_m/
//   up_y/down_y                 one-cycle adjust pulses
//   TO/T/TN                     31/30/28-29 day month flags
//   leap_year                   year mod 4 == 0
//   set_mode, field             not-RUN flag and current field (0..3)
// ---------------------------------------------------------------------------
module date_set_ctrl #(
  parameter int unsigned HOLD_CYC    = 500,
  parameter int unsigned RPT_CYC     = 100,
  parameter int unsigned TIMEOUT_CYC = 10000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       carry_h,
  input  logic       month_ten,
  input  logic [3:0] month_unit,
  input  logic [3:0] year_ten,
  input  logic [3:0] year_unit,
  output logic       en_d,
  output logic       up_d,
  output logic       down_d,
  output logic       up_m,
  output logic       down_m,
  output logic       up_y,
  output logic       down_y,
  output logic       TO,
  output logic       T,
  output logic       TN,
  output logic       leap_year,
  output logic       set_mode,
  output logic [1:0] field
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DAY   = 2'd1,
    ST_MONTH = 2'd2,
    ST_YEAR  = 2'd3
  } state_t;

  // Compare values clamped to the counter range: a counter that saturates
  // below a requested period simply never matches it.
  localparam longint unsigned CNT_MAX_L = (64'd1 << CNT_W) - 64'd1;
  localparam longint unsigned HOLD_L    = 64'(HOLD_CYC);
  localparam longint unsigned RPT_L     = 64'(RPT_CYC);
  localparam longint unsigned TO_L      = (TIMEOUT_CYC == 0) ? 64'd0 : 64'(TIMEOUT_CYC) - 64'd1;

  localparam logic [CNT_W-1:0] HOLD_V    = CNT_W'((HOLD_L > CNT_MAX_L) ? CNT_MAX_L : HOLD_L);
  localparam logic [CNT_W-1:0] RPT_V     = CNT_W'((RPT_L  > CNT_MAX_L) ? CNT_MAX_L : RPT_L);
  localparam logic [CNT_W-1:0] TO_LAST_V = CNT_W'((TO_L   > CNT_MAX_L) ? CNT_MAX_L : TO_L);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic             mode_prev_q, mode_prev_d;
  logic             up_prev_q, up_prev_d;
  logic             dn_prev_q, dn_prev_d;
  logic             init_q, init_d;
  logic             hold_act_q, hold_act_d;
  logic             hold_dir_q, hold_dir_d;   // 0 = up held, 1 = down held
  logic             rpt_q, rpt_d;             // 1 once the first repeat fired
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [5:0]       adj_q, adj_d;             // {down_y,up_y,down_m,up_m,down_d,up_d}

  logic mode_rise;
  logic up_rise;
  logic dn_rise;
  logic any_btn;
  logic fire;
  logic fire_dir;

  // init_q stays low for the first clock after reset so that buttons already
  // high at reset release are captured as previous samples, not edges.
  assign mode_rise = init_q & btn_mode & ~mode_prev_q;
  assign up_rise   = init_q & btn_up   & ~up_prev_q;
  assign dn_rise   = init_q & btn_down & ~dn_prev_q;
  assign any_btn   = btn_mode | btn_up | btn_down;

  always_comb begin
    state_d     = state_q;
    mode_prev_d = btn_mode;
    up_prev_d   = btn_up;
    dn_prev_d   = btn_down;
    init_d      = 1'b1;
    hold_act_d  = hold_act_q;
    hold_dir_d  = hold_dir_q;
    rpt_d       = rpt_q;
    hold_cnt_d  = hold_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    fire        = 1'b0;
    fire_dir    = 1'b0;
    adj_d       = '0;

    if (state_q == ST_RUN) begin
      hold_act_d = 1'b0;
      rpt_d      = 1'b0;
      hold_cnt_d = '0;
      idle_cnt_d = '0;
      if (mode_rise) begin
        state_d = ST_DAY;
      end
    end else begin
      // Idle timeout: any button level restarts the count.
      if (any_btn) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q == TO_LAST_V) begin
        idle_cnt_d = '0;
        state_d    = ST_RUN;
      end else begin
        idle_cnt_d = sat_inc(idle_cnt_q);
      end

      if (mode_rise) begin
        // Mode wins over a coincident adjust edge; the held button must be
        // re-pressed before it adjusts again.
        hold_act_d = 1'b0;
        rpt_d      = 1'b0;
        hold_cnt_d = '0;
        unique case (state_q)
          ST_DAY:   state_d = ST_MONTH;
          ST_MONTH: state_d = ST_YEAR;
          default:  state_d = ST_RUN;
        endcase
      end else if (btn_up && btn_down) begin
        hold_act_d = 1'b0;
        rpt_d      = 1'b0;
        hold_cnt_d = '0;
      end else if (up_rise || dn_rise) begin
        fire       = 1'b1;
        fire_dir   = dn_rise;
        hold_act_d = 1'b1;
        hold_dir_d = dn_rise;
        rpt_d      = 1'b0;
        hold_cnt_d = CNT_W'(1);
      end else if (hold_act_q && (hold_dir_q ? btn_down : btn_up)) begin
        // hold_cnt_q equals the number of clocks since the last pulse.
        if (hold_cnt_q == (rpt_q ? RPT_V : HOLD_V)) begin
          fire       = 1'b1;
          fire_dir   = hold_dir_q;
          rpt_d      = 1'b1;
          hold_cnt_d = CNT_W'(1);
        end else begin
          hold_cnt_d = sat_inc(hold_cnt_q);
        end
      end else begin
        hold_act_d = 1'b0;
        rpt_d      = 1'b0;
        hold_cnt_d = '0;
      end

      if (fire) begin
        unique case (state_q)
          ST_DAY:   adj_d = fire_dir ? 6'b000010 : 6'b000001;
          ST_MONTH: adj_d = fire_dir ? 6'b001000 : 6'b000100;
          ST_YEAR:  adj_d = fire_dir ? 6'b100000 : 6'b010000;
          default:  adj_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      mode_prev_q <= 1'b0;
      up_prev_q   <= 1'b0;
      dn_prev_q   <= 1'b0;
      init_q      <= 1'b0;
      hold_act_q  <= 1'b0;
      hold_dir_q  <= 1'b0;
      rpt_q       <= 1'b0;
      hold_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      adj_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= mode_prev_d;
      up_prev_q   <= up_prev_d;
      dn_prev_q   <= dn_prev_d;
      init_q      <= init_d;
      hold_act_q  <= hold_act_d;
      hold_dir_q  <= hold_dir_d;
      rpt_q       <= rpt_d;
      hold_cnt_q  <= hold_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      adj_q       <= adj_d;
    end
  end

  assign up_d     = adj_q[0];
  assign down_d   = adj_q[1];
  assign up_m     = adj_q[2];
  assign down_m   = adj_q[3];
  assign up_y     = adj_q[4];
  assign down_y   = adj_q[5];

  assign en_d     = carry_h & (state_q == ST_RUN);
  assign set_mode = (state_q != ST_RUN);
  assign field    = state_q;

  // Month length class; anything outside 01..12 or non-BCD decodes to none.
  always_comb begin
    TO = 1'b0;
    T  = 1'b0;
    TN = 1'b0;
    if (!month_ten) begin
      unique case (month_unit)
        4'd1, 4'd3, 4'd5, 4'd7, 4'd8: TO = 1'b1;
        4'd4, 4'd6, 4'd9:             T  = 1'b1;
        4'd2:                         TN = 1'b1;
        default: ;
      endcase
    end else begin
      unique case (month_unit)
        4'd0, 4'd2: TO = 1'b1;
        4'd1:       T  = 1'b1;
        default: ;
      endcase
    end
  end

  // year mod 4 == 0: 10*ten + unit is divisible by 4 exactly when
  // 2*ten + unit is, giving the even/odd tens-digit split below.
  always_comb begin
    leap_year = 1'b0;
    if ((year_ten <= 4'd9) && (year_unit <= 4'd9)) begin
      if (!year_ten[0]) begin
        leap_year = (year_unit == 4'd0) || (year_unit == 4'd4) || (year_unit == 4'd8);
      end else begin
        leap_year = (year_unit == 4'd2) || (year_unit == 4'd6);
      end
    end
  end

endmodule

// File: tb/tb_date_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_date_set_ctrl
//
// Directed bench for date_set_ctrl: enable gating, mode stepping, hold/repeat
// timing, two-button and mode-priority rules, month/leap decode, idle timeout
// and reset behaviour. Inputs change on the falling edge, outputs are checked
// on the falling edge (or shortly after an input change for combinational
// paths).
// ---------------------------------------------------------------------------
module tb_date_set_ctrl;

  localparam int unsigned HOLD    = 500;
  localparam int unsigned RPT     = 100;
  localparam int unsigned TIMEOUT = 10000;

  logic       clk;
  logic       rst_n;
  logic       btn_mode, btn_up, btn_down, carry_h;
  logic       month_ten;
  logic [3:0] month_unit, year_ten, year_unit;
  logic       en_d, up_d, down_d, up_m, down_m, up_y, down_y;
  logic       TO, T, TN, leap_year, set_mode;
  logic [1:0] field;
  logic [5:0] adj;

  int checks = 0;
  int errors = 0;

  date_set_ctrl #(
    .HOLD_CYC    (HOLD),
    .RPT_CYC     (RPT),
    .TIMEOUT_CYC (TIMEOUT),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .carry_h    (carry_h),
    .month_ten  (month_ten),
    .month_unit (month_unit),
    .year_ten   (year_ten),
    .year_unit  (year_unit),
    .en_d       (en_d),
    .up_d       (up_d),
    .down_d     (down_d),
    .up_m       (up_m),
    .down_m     (down_m),
    .up_y       (up_y),
    .down_y     (down_y),
    .TO         (TO),
    .T          (T),
    .TN         (TN),
    .leap_year  (leap_year),
    .set_mode   (set_mode),
    .field      (field)
  );

  assign adj = {down_y, up_y, down_m, up_m, down_d, up_d};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_date(input logic mt, input logic [3:0] mu, input logic [3:0] yt,
                          input logic [3:0] yu, input logic [3:0] exp_flags);
    month_ten  = mt;
    month_unit = mu;
    year_ten   = yt;
    year_unit  = yu;
    #1;
    // exp_flags = {TO, T, TN, leap_year}
    chk("date_decode", {4'h0, TO, T, TN, leap_year}, {4'h0, exp_flags});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_adj;

    rst_n      = 1'b0;
    btn_mode   = 1'b0;
    btn_up     = 1'b0;
    btn_down   = 1'b0;
    carry_h    = 1'b0;
    month_ten  = 1'b0;
    month_unit = 4'd1;
    year_ten   = 4'd2;
    year_unit  = 4'd4;

    // Reset state
    #3;
    chk("rst_adj",      {2'b0, adj},       8'h00);
    chk("rst_set_mode", {7'b0, set_mode},  8'h00);
    chk("rst_field",    {6'b0, field},     8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // RUN: carry_h passes straight to en_d
    carry_h = 1'b1;
    #1 chk("run_en_d_hi", {7'b0, en_d}, 8'h01);
    @(negedge clk);
    carry_h = 1'b0;
    #1 chk("run_en_d_lo", {7'b0, en_d}, 8'h00);
    @(negedge clk);

    // Three mode presses -> SET_YEAR, en_d blocked
    press_mode();
    chk("field_day", {6'b0, field}, 8'h01);
    press_mode();
    chk("field_month", {6'b0, field}, 8'h02);
    press_mode();
    chk("field_year", {6'b0, field}, 8'h03);
    carry_h = 1'b1;
    #1 chk("set_en_d_blocked", {7'b0, en_d}, 8'h00);
    chk("set_mode_hi", {7'b0, set_mode}, 8'h01);
    @(negedge clk);
    carry_h = 1'b0;
    press_mode();
    chk("field_run", {6'b0, field}, 8'h00);
    chk("set_mode_lo", {7'b0, set_mode}, 8'h00);
    press_mode();
    chk("field_day2", {6'b0, field}, 8'h01);

    // SET_DAY: hold btn_up for 1000 cycles
    btn_up = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      exp_adj = ((i == 0) || ((i >= int'(HOLD)) && (((i - int'(HOLD)) % int'(RPT)) == 0)))
                ? 8'h01 : 8'h00;
      chk("hold_repeat", {2'b0, adj}, exp_adj);
    end
    btn_up = 1'b0;
    @(negedge clk);

    // Single btn_down press -> one down_d pulse
    btn_down = 1'b1;
    @(negedge clk);
    chk("down_d_pulse", {2'b0, adj}, 8'h02);
    btn_down = 1'b0;
    @(negedge clk);
    chk("down_d_end", {2'b0, adj}, 8'h00);

    // SET_MONTH: both buttons together -> nothing, even after down release
    press_mode();
    chk("field_month2", {6'b0, field}, 8'h02);
    btn_up   = 1'b1;
    btn_down = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("both_no_pulse", {2'b0, adj}, 8'h00);
    end
    btn_down = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      chk("after_both_no_pulse", {2'b0, adj}, 8'h00);
    end
    btn_up = 1'b0;
    @(negedge clk);
    btn_up = 1'b1;
    @(negedge clk);
    chk("up_m_pulse", {2'b0, adj}, 8'h04);
    btn_up = 1'b0;
    @(negedge clk);
    chk("up_m_end", {2'b0, adj}, 8'h00);

    // Mode edge coinciding with up edge: mode wins, no repeat later
    btn_mode = 1'b1;
    btn_up   = 1'b1;
    @(negedge clk);
    chk("prio_field", {6'b0, field}, 8'h03);
    chk("prio_no_pulse", {2'b0, adj}, 8'h00);
    btn_mode = 1'b0;
    for (int i = 0; i < 520; i++) begin
      @(negedge clk);
      chk("prio_hold_no_pulse", {2'b0, adj}, 8'h00);
    end
    btn_up = 1'b0;
    @(negedge clk);

    // SET_YEAR: up_y pulse, then idle timeout
    btn_up = 1'b1;
    @(negedge clk);
    chk("up_y_pulse", {2'b0, adj}, 8'h10);
    btn_up = 1'b0;
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("timeout_not_yet", {7'b0, set_mode}, 8'h01);
    @(negedge clk);
    chk("timeout_set_mode", {7'b0, set_mode}, 8'h00);
    chk("timeout_field", {6'b0, field}, 8'h00);

    // Month / leap decode: {TO, T, TN, leap}
    chk_date(1'b0, 4'd2, 4'd0, 4'd0, 4'b0011);
    chk_date(1'b0, 4'd2, 4'd0, 4'd4, 4'b0011);
    chk_date(1'b0, 4'd2, 4'd2, 4'd4, 4'b0011);
    chk_date(1'b0, 4'd2, 4'd1, 4'd9, 4'b0010);
    chk_date(1'b1, 4'd3, 4'd1, 4'd9, 4'b0000);
    chk_date(1'b1, 4'd2, 4'd3, 4'd2, 4'b1001);
    chk_date(1'b1, 4'd1, 4'd3, 4'd0, 4'b0100);
    chk_date(1'b0, 4'd0, 4'd9, 4'd6, 4'b0001);
    chk_date(1'b0, 4'd9, 4'd1, 4'd10, 4'b0100);
    chk_date(1'b0, 4'd10, 4'd11, 4'd2, 4'b0000);
    chk_date(1'b0, 4'd7, 4'd7, 4'd6, 4'b1001);

    // Reset in the middle of a hold, with btn_mode high across release
    @(negedge clk);
    press_mode();
    chk("field_day3", {6'b0, field}, 8'h01);
    btn_up = 1'b1;
    @(negedge clk);
    chk("pre_rst_pulse", {2'b0, adj}, 8'h01);
    repeat (10) @(negedge clk);
    #2;
    rst_n    = 1'b0;
    btn_mode = 1'b1;
    #1;
    chk("midrst_adj",      {2'b0, adj},      8'h00);
    chk("midrst_set_mode", {7'b0, set_mode}, 8'h00);
    chk("midrst_field",    {6'b0, field},    8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("held_over_rst_field", {6'b0, field}, 8'h00);
      chk("held_over_rst_adj",   {2'b0, adj},   8'h00);
    end
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    @(negedge clk);
    press_mode();
    chk("field_after_rst", {6'b0, field}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
